cardinal_nic_vc: RTL and testbench

Parametrised successor to the single-entry cardinal NIC. It sits between a processor register port and one cardinal ring router port. It provides an IN_DEPTH-entry input FIFO (router to processor) and two OUT_DEPTH-entry output FIFOs, one per virtual channel (processor to router). Injection obeys the ring's even/odd net_polarity rule, with no head-of-line blocking across VCs. Sticky drop flags and occupancy counts are exposed in the status registers.

---
 rtl/cardinal_nic_vc.sv | 139 +++++++++++++
 tb/tb_cardinal_nic_vc.sv | 139 +++++++++++++
 2 files changed

// File: rtl/cardinal_nic_vc.sv
// Cardinal ring NIC with a router-to-processor input FIFO and one output FIFO per
// virtual channel; injection follows the even/odd net_polarity rule.

module cardinal_nic_vc_fifo #(
   parameter int W     = 64,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  logic [0:W-1]  din,
   output logic [0:W-1]  head,
   output logic [AW:0]   count
);
   logic [0:W-1]  mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;

   // Caller guarantees push only when not full and pop only when not empty.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= din;

   assign head = mem[rd_ptr];
endmodule

module cardinal_nic_vc #(
   parameter int PKT_WIDTH = 64,
   parameter int IN_DEPTH  = 4,
   parameter int OUT_DEPTH = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                nicEn,
   input  logic                nicWrEn,
   input  logic [0:1]          addr,
   input  logic [0:PKT_WIDTH-1] d_in,
   output logic [0:PKT_WIDTH-1] d_out,
   input  logic                net_si,
   output logic                net_ri,
   input  logic [0:PKT_WIDTH-1] net_di,
   output logic                net_so,
   input  logic                net_ro,
   output logic [0:PKT_WIDTH-1] net_do,
   input  logic                net_polarity
);
   localparam int ICW = $clog2(IN_DEPTH) + 1;
   localparam int OCW = $clog2(OUT_DEPTH) + 1;

   logic                 in_push, in_pop, in_full, in_empty, in_drop, in_drop_set;
   logic [0:PKT_WIDTH-1] in_head;
   logic [ICW-1:0]       in_count;
   logic                 proc_rd, out_wr, inj, out_drop, out_drop_set;

   logic [1:0][0:PKT_WIDTH-1] vc_head;
   logic [1:0][OCW-1:0]       vc_count;
   logic [1:0]                vc_full, vc_empty, vc_push, vc_pop;

   assign proc_rd = nicEn & ~nicWrEn;
   assign out_wr  = nicEn & nicWrEn & (addr == 2'b10);

   assign in_full     = (in_count == ICW'(IN_DEPTH));
   assign in_empty    = (in_count == '0);
   assign net_ri      = ~reset & ~in_full;
   assign in_push     = net_si & net_ri;
   assign in_drop_set = net_si & in_full;
   assign in_pop      = proc_rd & (addr == 2'b00) & ~in_empty;

   cardinal_nic_vc_fifo #(.W(PKT_WIDTH), .DEPTH(IN_DEPTH)) u_in_fifo (
      .clk(clk), .reset(reset), .push(in_push), .pop(in_pop),
      .din(net_di), .head(in_head), .count(in_count));

   // Only the VC matching the current polarity may launch; the other never stalls it.
   assign inj          = net_ro & ~vc_empty[net_polarity];
   assign out_drop_set = out_wr & vc_full[d_in[0]];

   for (genvar g = 0; g < 2; g++) begin : g_vc
      assign vc_full[g]  = (vc_count[g] == OCW'(OUT_DEPTH));
      assign vc_empty[g] = (vc_count[g] == '0);
      assign vc_push[g]  = out_wr & (d_in[0] == 1'(g)) & ~vc_full[g];
      assign vc_pop[g]   = inj & (net_polarity == 1'(g));

      cardinal_nic_vc_fifo #(.W(PKT_WIDTH), .DEPTH(OUT_DEPTH)) u_vc_fifo (
         .clk(clk), .reset(reset), .push(vc_push[g]), .pop(vc_pop[g]),
         .din(d_in), .head(vc_head[g]), .count(vc_count[g]));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         net_so   <= 1'b0;
         net_do   <= '0;
         in_drop  <= 1'b0;
         out_drop <= 1'b0;
      end else begin
         net_so <= inj;
         if (inj) net_do <= vc_head[net_polarity];
         // A fresh drop in the same cycle as a status read keeps the flag set.
         in_drop  <= in_drop_set  | (in_drop  & ~(proc_rd & (addr == 2'b01)));
         out_drop <= out_drop_set | (out_drop & ~(proc_rd & (addr == 2'b11)));
      end
   end

   always_comb begin
      d_out = '0;
      if (proc_rd) begin
         case (addr)
            2'b00: if (!in_empty) d_out = in_head;
            2'b01: begin
               d_out[PKT_WIDTH-1]                  = ~in_empty;
               d_out[PKT_WIDTH-2]                  = in_drop;
               d_out[PKT_WIDTH-2-ICW:PKT_WIDTH-3]  = in_count;
            end
            2'b11: begin
               d_out[PKT_WIDTH-1] = vc_full[0] | vc_full[1];
               d_out[PKT_WIDTH-2] = vc_full[0];
               d_out[PKT_WIDTH-3] = vc_full[1];
               d_out[PKT_WIDTH-4] = out_drop;
            end
            default: d_out = '0;
         endcase
      end
   end
endmodule

// File: tb/tb_cardinal_nic_vc.sv
// Randomized bench for cardinal_nic_vc against a queue-based model of the NIC rules.

module tb_cardinal_nic_vc;
   localparam int PW = 64;
   localparam int ID = 4;
   localparam int OD = 4;

   logic          clk = 1'b0;
   logic          reset, nicEn, nicWrEn, net_si, net_ro, net_polarity;
   logic [0:1]    addr;
   logic [0:PW-1] d_in, net_di, d_out, net_do;
   logic          net_ri, net_so;

   cardinal_nic_vc #(.PKT_WIDTH(PW), .IN_DEPTH(ID), .OUT_DEPTH(OD)) dut (
      .clk(clk), .reset(reset), .nicEn(nicEn), .nicWrEn(nicWrEn), .addr(addr),
      .d_in(d_in), .d_out(d_out), .net_si(net_si), .net_ri(net_ri),
      .net_di(net_di), .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
      .net_polarity(net_polarity));

   always #5 clk = ~clk;

   int n_cmp = 0, n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %h, want %h", tag, $time, got, exp);
      end
   endtask

   // Reference state: plain queues and flags.
   logic [0:PW-1] inq[$];
   logic [0:PW-1] vcq[2][$];
   bit            m_idrop, m_odrop, m_so;
   logic [0:PW-1] m_do;

   function automatic logic [63:0] exp_dout();
      logic [63:0] r = '0;
      if (nicEn && !nicWrEn) begin
         case (addr)
            2'd0: r = (inq.size() > 0) ? inq[0] : '0;
            2'd1: r = (inq.size() > 0 ? 64'd1 : 64'd0) + (m_idrop ? 64'd2 : 64'd0)
                      + (64'(inq.size()) << 2);
            2'd3: r = ((vcq[0].size() == OD || vcq[1].size() == OD) ? 64'd1 : 64'd0)
                      + (vcq[0].size() == OD ? 64'd2 : 64'd0)
                      + (vcq[1].size() == OD ? 64'd4 : 64'd0)
                      + (m_odrop ? 64'd8 : 64'd0);
            default: r = '0;
         endcase
      end
      return r;
   endfunction

   task automatic model_edge();
      int isz, vsz[2], v, w;
      bit rd;
      if (reset) begin
         inq.delete(); vcq[0].delete(); vcq[1].delete();
         m_idrop = 0; m_odrop = 0; m_so = 0; m_do = '0;
         return;
      end
      isz = inq.size(); vsz[0] = vcq[0].size(); vsz[1] = vcq[1].size();
      rd  = nicEn && !nicWrEn;
      v   = int'(net_polarity);
      if (net_ro && vsz[v] > 0) begin
         m_so = 1; m_do = vcq[v].pop_front();
      end else m_so = 0;
      if (rd && addr == 2'd0 && isz > 0) void'(inq.pop_front());
      m_idrop = (net_si && isz == ID) || (m_idrop && !(rd && addr == 2'd1));
      if (net_si && isz < ID) inq.push_back(net_di);
      w = int'(d_in[0]);
      m_odrop = (nicEn && nicWrEn && addr == 2'd2 && vsz[w] == OD)
                || (m_odrop && !(rd && addr == 2'd3));
      if (nicEn && nicWrEn && addr == 2'd2 && vsz[w] < OD) vcq[w].push_back(d_in);
   endtask

   // One cycle: inputs already set at the falling edge; check comb outputs,
   // then advance the model at the edge and check registered outputs.
   task automatic cyc();
      #1;
      chk("d_out", d_out, exp_dout());
      chk("net_ri", 64'(net_ri), 64'(!reset && inq.size() < ID));
      @(posedge clk);
      model_edge();
      #1;
      chk("net_so", 64'(net_so), 64'(m_so));
      chk("net_do", net_do, m_do);
      @(negedge clk);
   endtask

   function automatic bit pct(input int p);
      return ($urandom_range(99) < p);
   endfunction

   // Biased random traffic. vc0p: percent of writes forced onto VC0 (-1 = random).
   task automatic rnd(input int n, input int psi, input int pen, input int pwr,
                      input int pro, input int prst, input int vc0p, input int wr_addr_fixed);
      for (int i = 0; i < n; i++) begin
         reset        = pct(prst);
         nicEn        = pct(pen);
         nicWrEn      = pct(pwr);
         addr         = 2'($urandom_range(3));
         if (nicWrEn && wr_addr_fixed != 0) addr = 2'd2;
         d_in         = {$urandom, $urandom};
         if (vc0p >= 0) d_in[0] = !pct(vc0p);
         net_si       = pct(psi);
         net_di       = {$urandom, $urandom};
         net_ro       = pct(pro);
         net_polarity = 1'($urandom_range(1));
         cyc();
      end
   endtask

   initial begin
      reset = 1; nicEn = 0; nicWrEn = 0; addr = 0; d_in = '0;
      net_si = 0; net_di = '0; net_ro = 0; net_polarity = 0;
      @(negedge clk);
      for (int i = 0; i < 5; i++) cyc();
      reset = 0; nicEn = 1; addr = 2'd1; cyc();
      addr = 2'd3; cyc();
      // Router floods with no reads, then drains through 00/01 reads.
      rnd(10, 100, 0, 0, 0, 0, -1, 0);
      rnd(12, 0, 100, 0, 0, 0, -1, 0);
      // Processor writes with random VCs, polarity and router backpressure.
      rnd(60, 0, 90, 90, 70, 0, -1, 1);
      // VC0 saturation with router blocked, then release.
      rnd(12, 0, 100, 80, 0, 0, 85, 1);
      rnd(20, 0, 60, 30, 100, 0, -1, 1);
      // Concurrent router pushes and processor pops.
      rnd(40, 70, 80, 10, 50, 0, -1, 0);
      // Fill everything, then reset mid-operation.
      rnd(15, 100, 100, 100, 0, 0, 50, 1);
      rnd(1, 100, 100, 100, 100, 100, -1, 1);
      rnd(500, 50, 70, 50, 60, 2, -1, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
